// File: rtl/iterative_vector_divider.sv
// iterative_vector_divider
//   Multi-cycle SIMD integer divide/remainder unit. Every lane runs its own
//   radix-2 restoring division. One shared FSM steps all lanes together, and
//   only one operation is in flight at a time. Issue logic uses a
//   req/busy/finished handshake.
//
// Parameters
//   DATA_WIDTH / BIT_WIDTH : width of one lane operand/result
//   LANES                  : number of lanes
//   VEC_WORD_WIDTH         : LANES*BIT_WIDTH, width of every vector port
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   stall     in   freezes all internal state
//   flush     in   aborts the in-flight operation; takes priority over stall and req
//   req       in   start request; operands and divCode are sampled in the same cycle
//   divCode   in   0=DIV, 1=DIVU, 2=REM, 3=REMU
//   fuOpA_In  in   dividend lanes
//   fuOpB_In  in   divisor lanes
//   busy      out  high while DIVIDING or FINISH
//   finished  out  result-valid strobe, held only while stalled in FINISH
//   dataOut   out  per-lane quotient or remainder, held until the next result
//
// Optional build macro
//   RSD_VECTOR_DIVIDER_SPECIAL_BYPASS_EN : when every lane is divide-by-zero or
//   signed overflow at issue, go straight to FINISH (result one cycle after req).
module iterative_vector_divider #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BIT_WIDTH      = DATA_WIDTH,
  parameter int unsigned LANES          = 4,
  parameter int unsigned VEC_WORD_WIDTH = LANES * BIT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      req,
  input  logic [1:0]                divCode,
  input  logic [VEC_WORD_WIDTH-1:0] fuOpA_In,
  input  logic [VEC_WORD_WIDTH-1:0] fuOpB_In,
  output logic                      busy,
  output logic                      finished,
  output logic [VEC_WORD_WIDTH-1:0] dataOut
);

  localparam int unsigned W     = BIT_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIVIDING = 2'd1,
    FINISH   = 2'd2
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      busy_q;
  logic                      finished_q;
  logic [VEC_WORD_WIDTH-1:0] data_q;
  logic                      is_rem_q;

  // Per-lane state. quo_q starts as the dividend magnitude and fills with
  // quotient bits from the bottom as the dividend bits shift out of the top.
  logic [W-1:0]     quo_q [LANES];
  logic [W:0]       rem_q [LANES];
  logic [W-1:0]     dvs_q [LANES];
  logic [W-1:0]     dvd_q [LANES];  // raw dividend: the remainder of a divide by zero
  logic [LANES-1:0] negq_q, negr_q, div0_q, ovf_q;

  // Lane values derived from the operands at issue
  logic [W-1:0]     quo_init [LANES];
  logic [W-1:0]     dvs_init [LANES];
  logic [LANES-1:0] negq_init, negr_init, div0_init, ovf_init;

  // One restoring step, plus the signed/special result produced from it
  logic [W-1:0]              quo_d [LANES];
  logic [W:0]                rem_d [LANES];
  logic [VEC_WORD_WIDTH-1:0] result_c;

  assign busy     = busy_q;
  assign finished = finished_q;
  assign dataOut  = data_q;

  // RISC-V values for divide-by-zero and signed overflow
  function automatic logic [W-1:0] special_val(input logic          is_rem,
                                               input logic          div0,
                                               input logic [W-1:0]  a);
    if (div0) return is_rem ? a : '1;
    return is_rem ? '0 : MIN_VAL;
  endfunction

  always_comb begin
    logic [W-1:0] a, b, qmag, rmag;
    logic [W+1:0] trial, diff;
    logic         signed_op;
    a         = '0;
    b         = '0;
    qmag      = '0;
    rmag      = '0;
    trial     = '0;
    diff      = '0;
    signed_op = ~divCode[0];
    negq_init = '0;
    negr_init = '0;
    div0_init = '0;
    ovf_init  = '0;
    result_c  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a = fuOpA_In[l*W +: W];
      b = fuOpB_In[l*W +: W];
      negr_init[l] = signed_op & a[W-1];
      negq_init[l] = (signed_op & a[W-1]) ^ (signed_op & b[W-1]);
      div0_init[l] = (b == '0);
      ovf_init[l]  = signed_op & (a == MIN_VAL) & (b == '1);
      quo_init[l]  = (signed_op & a[W-1]) ? -a : a;
      dvs_init[l]  = (signed_op & b[W-1]) ? -b : b;

      // Bring down the next dividend bit, then trial-subtract the divisor.
      // A negative difference (MSB set) means the old value is restored.
      trial = {rem_q[l], quo_q[l][W-1]};
      diff  = trial - {2'b00, dvs_q[l]};
      if (diff[W+1]) begin
        rem_d[l] = trial[W:0];
        quo_d[l] = {quo_q[l][W-2:0], 1'b0};
      end else begin
        rem_d[l] = diff[W:0];
        quo_d[l] = {quo_q[l][W-2:0], 1'b1};
      end

      // Result of the final step with the sign fix-up applied; the FSM latches
      // it on the same edge as that last step
      qmag = quo_d[l];
      rmag = rem_d[l][W-1:0];
      if (div0_q[l] || ovf_q[l])
        result_c[l*W +: W] = special_val(is_rem_q, div0_q[l], dvd_q[l]);
      else if (is_rem_q)
        result_c[l*W +: W] = negr_q[l] ? -rmag : rmag;
      else
        result_c[l*W +: W] = negq_q[l] ? -qmag : qmag;
    end
  end

`ifdef RSD_VECTOR_DIVIDER_SPECIAL_BYPASS_EN
  logic                      bypass_c;
  logic [VEC_WORD_WIDTH-1:0] bypass_res_c;

  always_comb begin
    bypass_c     = &(div0_init | ovf_init);
    bypass_res_c = '0;
    for (int unsigned l = 0; l < LANES; l++)
      bypass_res_c[l*W +: W] = special_val(divCode[1], div0_init[l], fuOpA_In[l*W +: W]);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      data_q     <= '0;
      is_rem_q   <= 1'b0;
      negq_q     <= '0;
      negr_q     <= '0;
      div0_q     <= '0;
      ovf_q      <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        quo_q[l] <= '0;
        rem_q[l] <= '0;
        dvs_q[l] <= '0;
        dvd_q[l] <= '0;
      end
    end else if (flush) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        IDLE, FINISH: begin
          finished_q <= 1'b0;
          if (req) begin
            is_rem_q <= divCode[1];
            negq_q   <= negq_init;
            negr_q   <= negr_init;
            div0_q   <= div0_init;
            ovf_q    <= ovf_init;
            for (int unsigned l = 0; l < LANES; l++) begin
              quo_q[l] <= quo_init[l];
              rem_q[l] <= '0;
              dvs_q[l] <= dvs_init[l];
              dvd_q[l] <= fuOpA_In[l*W +: W];
            end
            busy_q <= 1'b1;
`ifdef RSD_VECTOR_DIVIDER_SPECIAL_BYPASS_EN
            if (bypass_c) begin
              state_q    <= FINISH;
              finished_q <= 1'b1;
              data_q     <= bypass_res_c;
            end else
`endif
            begin
              state_q <= DIVIDING;
              cnt_q   <= CNT_W'(W - 1);
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DIVIDING: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            quo_q[l] <= quo_d[l];
            rem_q[l] <= rem_d[l];
          end
          if (cnt_q == '0) begin
            state_q    <= FINISH;
            finished_q <= 1'b1;
            data_q     <= result_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_vector_divider.sv
// Self-checking bench for iterative_vector_divider (4 lanes x 32 bits).
// Expected results come from a reference model that uses plain integer
// division with the RISC-V divide-by-zero and overflow rules.
module tb_iterative_vector_divider;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 4;
  localparam int unsigned VW = W * L;
  localparam logic [W-1:0] MINV = 32'h8000_0000;
`ifdef RSD_VECTOR_DIVIDER_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, flush, req;
  logic [1:0]    divCode;
  logic [VW-1:0] opA, opB;
  logic          busy, finished;
  logic [VW-1:0] dataOut;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [VW-1:0] exp_out;

  always #5 clk = ~clk;

  iterative_vector_divider #(
    .DATA_WIDTH    (W),
    .BIT_WIDTH     (W),
    .LANES         (L),
    .VEC_WORD_WIDTH(VW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .req     (req),
    .divCode (divCode),
    .fuOpA_In(opA),
    .fuOpB_In(opB),
    .busy    (busy),
    .finished(finished),
    .dataOut (dataOut)
  );

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] vec(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic bit is_special(input logic [1:0] code, input logic [W-1:0] a, b);
    return (b == 0) || (!code[0] && a == MINV && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] ref_lane(input logic [1:0] code, input logic [W-1:0] a, b);
    int sa, sb;
    sa = a;
    sb = b;
    case (code)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return W'(sa / sb);
      end
      2'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'd2: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 0;
        return W'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue from IDLE or FINISH, optionally stall for stall_len cycles starting
  // stall_at cycles after the request, then check latency and result.
  task automatic run_op(input logic [1:0] code, input logic [VW-1:0] a, b,
                        input string tag, input int unsigned stall_at, input int unsigned stall_len);
    int unsigned   cyc, exp_lat;
    bit            all_sp;
    logic [VW-1:0] expv;
    all_sp = 1'b1;
    for (int unsigned l = 0; l < L; l++) begin
      expv[l*W +: W] = ref_lane(code, a[l*W +: W], b[l*W +: W]);
      if (!is_special(code, a[l*W +: W], b[l*W +: W])) all_sp = 1'b0;
    end
    exp_lat = (BYPASS && all_sp) ? 1 : W + 1 + stall_len;
    divCode = code;
    opA = a;
    opB = b;
    req = 1'b1;
    step();
    req = 1'b0;
    opA = {$urandom, $urandom, $urandom, $urandom};
    opB = {$urandom, $urandom, $urandom, $urandom};
    divCode = 2'($urandom_range(0, 3));
    cyc = 1;
    while (!finished && cyc < 200) begin
      stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      step();
      cyc++;
    end
    stall = 1'b0;
    check({tag, "_latency"}, VW'(cyc), VW'(exp_lat));
    check({tag, "_data"}, dataOut, expv);
    check({tag, "_busy"}, VW'(busy), VW'(1));
    exp_out = expv;
  endtask

  initial begin
    logic [VW-1:0] a, b;
    logic [1:0]    code;
    bit            saw_fin;

    rst = 1'b0; stall = 1'b0; flush = 1'b0; req = 1'b0;
    divCode = '0; opA = '0; opB = '0; exp_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", VW'(busy), '0);
    check("rst_finished", VW'(finished), '0);
    check("rst_data", dataOut, '0);
    rst = 1'b1;
    step();

    // Unsigned and signed basics
    a = vec(100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    b = vec(7, 1, 1, 1);
    run_op(2'd1, a, b, "divu", 0, 0);
    run_op(2'd3, a, b, "remu", 0, 0);
    a = vec(-32'sd100, 100, 12345, -32'sd9);
    b = vec(7, -32'sd7, 10, 4);
    run_op(2'd0, a, b, "div", 0, 0);
    run_op(2'd2, a, b, "rem", 0, 0);
    step();
    check("idle_busy", VW'(busy), '0);
    check("idle_finished", VW'(finished), '0);
    check("idle_data_hold", dataOut, exp_out);

    // Special cases
    run_op(2'd1, vec(5, 5, 5, 5), '0, "divu_zero", 0, 0);
    run_op(2'd3, vec(5, 5, 5, 5), '0, "remu_zero", 0, 0);
    run_op(2'd0, vec(MINV, MINV, MINV, MINV), '1, "div_ovf", 0, 0);
    run_op(2'd2, vec(MINV, MINV, MINV, MINV), '1, "rem_ovf", 0, 0);
    run_op(2'd0, vec(MINV, 5, 100, 7), vec(32'hFFFF_FFFF, 0, 7, 0), "div_mixed", 0, 0);
    run_op(2'd2, vec(-32'sd5, 9, 100, 7), vec(0, 0, 0, 0), "rem_zero_signed", 0, 0);

    // Stall mid-DIVIDING adds 1:1 to latency
    run_op(2'd1, vec(1000, 77, 65535, 3), vec(3, 7, 255, 5), "stall_mid", 5, 4);

    // Stall in FINISH holds the strobe and data
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stallfin_finished", VW'(finished), VW'(1));
      check("stallfin_data", dataOut, exp_out);
    end
    stall = 1'b0;
    step();
    check("after_stallfin_finished", VW'(finished), '0);
    check("after_stallfin_busy", VW'(busy), '0);

    // Flush at cycle 10 of DIVIDING
    divCode = 2'd1; opA = vec(999, 999, 999, 999); opB = vec(2, 3, 4, 5); req = 1'b1;
    step();
    req = 1'b0;
    check("flush_busy_before", VW'(busy), VW'(1));
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", VW'(busy), '0);
    check("flush_finished", VW'(finished), '0);
    saw_fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (finished) saw_fin = 1'b1;
    end
    check("flush_no_pulse", VW'(saw_fin), '0);
    check("flush_data_kept", dataOut, exp_out);

    // Flush with simultaneous req is dropped
    flush = 1'b1; req = 1'b1;
    step();
    flush = 1'b0; req = 1'b0;
    check("flushreq_busy", VW'(busy), '0);
    step();
    check("flushreq_busy2", VW'(busy), '0);
    check("flushreq_finished", VW'(finished), '0);

    // Back-to-back: the second request lands in FINISH
    run_op(2'd0, vec(-32'sd77, 81, 3, 32'h7FFF_FFFF), vec(5, -32'sd9, 1000, 2), "b2b_first", 0, 0);
    run_op(2'd3, vec(123456, 42, 7, 32'hDEAD_BEEF), vec(1000, 42, 9, 32'h1234), "b2b_second", 0, 0);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      code = 2'($urandom_range(0, 3));
      for (int unsigned l = 0; l < L; l++) begin
        int unsigned kind;
        kind = $urandom_range(0, 9);
        a[l*W +: W] = $urandom;
        b[l*W +: W] = $urandom;
        if (kind == 0) b[l*W +: W] = '0;
        else if (kind == 1) begin a[l*W +: W] = MINV; b[l*W +: W] = '1; end
        else if (kind < 5) b[l*W +: W] = W'($urandom_range(1, 15));
        else if (kind == 5) b[l*W +: W] = -W'($urandom_range(1, 15));
      end
      if (n == 7) b = '0;
      run_op(code, a, b, "random", 0, 0);
      if (n % 3 == 2) step();
    end

    // Asynchronous reset mid-DIVIDING
    divCode = 2'd0; opA = vec(500, 600, 700, 800); opB = vec(3, 3, 3, 3); req = 1'b1;
    step();
    req = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("arst_busy", VW'(busy), '0);
    check("arst_finished", VW'(finished), '0);
    check("arst_data", dataOut, '0);
    step();
    rst = 1'b1;
    step();
    check("arst_idle_busy", VW'(busy), '0);
    run_op(2'd1, vec(100, 200, 300, 400), vec(7, 7, 7, 7), "post_reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
